// File: rtl/stack_pkg.sv
// Shared definitions for the stack CPU instruction-memory arbiter:
// bus width, RAM write-enable patterns and the arbiter FSM encoding.
package stack_pkg;

    localparam int         CPU_BIT_WIDTH = 32;
    localparam logic [3:0] RAM_WE_ALL    = 4'hF;
    localparam logic [3:0] RAM_WE_NONE   = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_FETCH_WAIT = 2'd2,
        ST_FETCH_CAPT = 2'd3
    } arb_state_e;

    function automatic logic is_fetch_state(input arb_state_e s);
        return (s == ST_FETCH_WAIT) || (s == ST_FETCH_CAPT);
    endfunction

endpackage

// File: rtl/stack_imem_arbiter_if.sv
// Bundle of CPU-fetch, loader and RAM-side signals around the instruction-memory arbiter.
// slave = arbiter view, master = environment (CPU, loader, RAM) view.
interface stack_imem_arbiter_if;
    import stack_pkg::*;

    logic                     fetch_en;
    logic                     cpu_inst_complete;
    logic [CPU_BIT_WIDTH-1:0] cpu_pc_next;
    logic [CPU_BIT_WIDTH-1:0] cpu_inst;
    logic                     cpu_inst_ready;
    logic                     ld_req;
    logic [CPU_BIT_WIDTH-1:0] ld_addr;
    logic [CPU_BIT_WIDTH-1:0] ld_data;
    logic                     ld_ack;
    logic [3:0]               ram_we;
    logic [CPU_BIT_WIDTH-1:0] ram_addr;
    logic [CPU_BIT_WIDTH-1:0] ram_data_in;
    logic [CPU_BIT_WIDTH-1:0] ram_data_out;
    logic                     fetch_ovf;

    modport slave (
        input  fetch_en, cpu_inst_complete, cpu_pc_next,
               ld_req, ld_addr, ld_data, ram_data_out,
        output cpu_inst, cpu_inst_ready, ld_ack,
               ram_we, ram_addr, ram_data_in, fetch_ovf
    );

    modport master (
        output fetch_en, cpu_inst_complete, cpu_pc_next,
               ld_req, ld_addr, ld_data, ram_data_out,
        input  cpu_inst, cpu_inst_ready, ld_ack,
               ram_we, ram_addr, ram_data_in, fetch_ovf
    );

endinterface

// File: rtl/stack_arb_starve_cnt.sv
// Saturating count of fetch grants issued while the loader is waiting;
// sat tells the arbiter the loader must be served next.
module stack_arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int            CW    = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign a default to every output first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking belongs in always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/stack_imem_arbiter.sv
// Shares the single-port instruction RAM between CPU fetches and a program loader,
// returning fetched words with a ready pulse and bounding loader starvation.
module stack_imem_arbiter
    import stack_pkg::*;
#(
    parameter int RD_LATENCY  = 1,
    parameter int LD_MAX_WAIT = 4
) (
    input logic                  clk,
    input logic                  rst,
    stack_imem_arbiter_if.slave  bus
);

    localparam int             W       = CPU_BIT_WIDTH;
    localparam int             WCW     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LD = WCW'(RD_LATENCY - 1);

    arb_state_e     state_q, state_d;
    logic           prev_complete_q, prev_complete_d;
    logic           fetch_pend_q, fetch_pend_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [W-1:0]   cpu_inst_q, cpu_inst_d;
    logic           inst_ready_q, inst_ready_d;
    logic           ld_ack_q, ld_ack_d;
    logic [3:0]     ram_we_q, ram_we_d;
    logic [W-1:0]   ram_addr_q, ram_addr_d;
    logic [W-1:0]   ram_data_in_q, ram_data_in_d;
    logic           fetch_ovf_q, fetch_ovf_d;

    logic           req_edge;
    logic           fetch_req;
    logic           fetch_go;
    logic           ld_req_eff;
    logic [W-1:0]   fetch_addr;
    logic           starve_inc;
    logic           starve_clr;
    logic           starve_sat;

    stack_arb_starve_cnt #(
        .MAX (LD_MAX_WAIT)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (starve_sat)
    );

    assign req_edge   = bus.cpu_inst_complete & ~prev_complete_q;
    // A same-cycle request edge is arbitrated immediately, using the address on the bus.
    assign fetch_req  = fetch_pend_q | req_edge;
    assign fetch_addr = fetch_pend_q ? pc_q : bus.cpu_pc_next;
    assign fetch_go   = fetch_req & bus.fetch_en;
    // The loader still holds ld_req during its ack cycle; that level is stale.
    assign ld_req_eff = bus.ld_req & ~ld_ack_q;

    always_comb begin
        state_d         = state_q;
        prev_complete_d = bus.cpu_inst_complete;
        fetch_pend_d    = fetch_pend_q;
        pc_d            = pc_q;
        wait_cnt_d      = wait_cnt_q;
        cpu_inst_d      = cpu_inst_q;
        inst_ready_d    = 1'b0;
        ld_ack_d        = 1'b0;
        ram_we_d        = RAM_WE_NONE;
        ram_addr_d      = ram_addr_q;
        ram_data_in_d   = ram_data_in_q;
        fetch_ovf_d     = fetch_ovf_q;
        starve_inc      = 1'b0;
        starve_clr      = 1'b0;

        if (req_edge) begin
            fetch_pend_d = 1'b1;
            if (fetch_pend_q || is_fetch_state(state_q)) begin
                fetch_ovf_d = 1'b1;
            end else begin
                pc_d = bus.cpu_pc_next;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ld_req_eff && (starve_sat || !fetch_go)) begin
                    ram_we_d      = RAM_WE_ALL;
                    ram_addr_d    = bus.ld_addr;
                    ram_data_in_d = bus.ld_data;
                    starve_clr    = 1'b1;
                    state_d       = ST_WRITE;
                end else if (fetch_go) begin
                    ram_addr_d   = fetch_addr;
                    fetch_pend_d = 1'b0;
                    wait_cnt_d   = WAIT_LD;
                    starve_inc   = ld_req_eff;
                    starve_clr   = ~ld_req_eff;
                    state_d      = ST_FETCH_WAIT;
                end else begin
                    starve_clr = ~ld_req_eff;
                end
            end
            ST_WRITE: begin
                ld_ack_d = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_FETCH_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_FETCH_CAPT;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
            ST_FETCH_CAPT: begin
                cpu_inst_d   = bus.ram_data_out;
                inst_ready_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            prev_complete_q <= 1'b0;
            fetch_pend_q    <= 1'b0;
            pc_q            <= '0;
            wait_cnt_q      <= '0;
            cpu_inst_q      <= '0;
            inst_ready_q    <= 1'b0;
            ld_ack_q        <= 1'b0;
            ram_we_q        <= RAM_WE_NONE;
            ram_addr_q      <= '0;
            ram_data_in_q   <= '0;
            fetch_ovf_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_complete_q <= prev_complete_d;
            fetch_pend_q    <= fetch_pend_d;
            pc_q            <= pc_d;
            wait_cnt_q      <= wait_cnt_d;
            cpu_inst_q      <= cpu_inst_d;
            inst_ready_q    <= inst_ready_d;
            ld_ack_q        <= ld_ack_d;
            ram_we_q        <= ram_we_d;
            ram_addr_q      <= ram_addr_d;
            ram_data_in_q   <= ram_data_in_d;
            fetch_ovf_q     <= fetch_ovf_d;
        end
    end

    assign bus.cpu_inst       = cpu_inst_q;
    assign bus.cpu_inst_ready = inst_ready_q;
    assign bus.ld_ack         = ld_ack_q;
    assign bus.ram_we         = ram_we_q;
    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_data_in    = ram_data_in_q;
    assign bus.fetch_ovf      = fetch_ovf_q;

endmodule

// File: tb/tb_stack_imem_arbiter.sv
// Directed bench for stack_imem_arbiter with a 1-cycle-latency word RAM model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stack_imem_arbiter;

    logic clk;
    logic rst;

    stack_imem_arbiter_if bus();

    stack_imem_arbiter #(
        .RD_LATENCY  (1),
        .LD_MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed RAM model with a backdoor preload port.
    logic [31:0] mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (bus.ram_we == 4'hF) begin
            mem[bus.ram_addr[7:2]] <= bus.ram_data_in;
        end
        bus.ram_data_out <= mem[bus.ram_addr[7:2]];
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Called on a falling edge with the arbiter idle; expects ready 3 cycles later.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp, input string tag);
        int lat;
        lat = 0;
        bus.cpu_inst_complete = 1'b1;
        bus.cpu_pc_next       = pc;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.cpu_inst_complete = 1'b0;
        end while (!bus.cpu_inst_ready && lat < 12);
        check({tag, " latency"}, lat, 3);
        check({tag, " data"}, bus.cpu_inst, exp);
        @(negedge clk);
        check({tag, " single pulse"}, bus.cpu_inst_ready, 1'b0);
    endtask

    // Called on a falling edge; loader write must issue and be acknowledged.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int lat;
        lat = 0;
        bus.ld_req  = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.ram_we != 4'hF && lat < 12);
        check({tag, " we"}, bus.ram_we, 4'hF);
        check({tag, " addr"}, bus.ram_addr, addr);
        check({tag, " wdata"}, bus.ram_data_in, data);
        @(negedge clk);
        check({tag, " ack"}, bus.ld_ack, 1'b1);
        bus.ld_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fetches;
        int writes;
        int at_write;
        logic raised;

        rst = 1'b1;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        bus.fetch_en = 1'b1;
        bus.cpu_inst_complete = 1'b0;
        bus.cpu_pc_next = '0;
        bus.ld_req = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;

        // Reset state, with RAM preloads done meanwhile.
        @(negedge clk);
        preload(6'd2,  32'hDEAD0001);
        preload(6'd8,  32'h0000_3232);
        preload(6'd10, 32'h0000_4040);
        preload(6'd11, 32'h4444_4444);
        check("rst cpu_inst", bus.cpu_inst, 32'h0);
        check("rst inst_ready", bus.cpu_inst_ready, 1'b0);
        check("rst ld_ack", bus.ld_ack, 1'b0);
        check("rst ram_we", bus.ram_we, 4'h0);
        check("rst ram_addr", bus.ram_addr, 32'h0);
        check("rst ram_data_in", bus.ram_data_in, 32'h0);
        check("rst fetch_ovf", bus.fetch_ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single fetch, cycle-accurate latency.
        bus.cpu_inst_complete = 1'b1;
        bus.cpu_pc_next = 32'd8;
        @(negedge clk);
        check("t1 ram_addr T+1", bus.ram_addr, 32'd8);
        check("t1 ram_we T+1", bus.ram_we, 4'h0);
        check("t1 ready T+1", bus.cpu_inst_ready, 1'b0);
        bus.cpu_inst_complete = 1'b0;
        @(negedge clk);
        check("t1 ready T+2", bus.cpu_inst_ready, 1'b0);
        @(negedge clk);
        check("t1 ready T+3", bus.cpu_inst_ready, 1'b1);
        check("t1 inst T+3", bus.cpu_inst, 32'hDEAD0001);
        @(negedge clk);
        check("t1 ready T+4", bus.cpu_inst_ready, 1'b0);
        check("t1 inst held", bus.cpu_inst, 32'hDEAD0001);

        // 2: loader write; ld_req still high in the ack cycle must not re-issue.
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'd4;
        bus.ld_data = 32'h12345678;
        @(negedge clk);
        check("t2 we", bus.ram_we, 4'hF);
        check("t2 addr", bus.ram_addr, 32'd4);
        check("t2 wdata", bus.ram_data_in, 32'h12345678);
        check("t2 ack early", bus.ld_ack, 1'b0);
        @(negedge clk);
        check("t2 ack", bus.ld_ack, 1'b1);
        check("t2 we dropped", bus.ram_we, 4'h0);
        @(negedge clk);
        check("t2 no reissue", bus.ram_we, 4'h0);
        check("t2 ack pulse", bus.ld_ack, 1'b0);
        bus.ld_req = 1'b0;
        @(negedge clk);
        check("t2 no reissue late", bus.ram_we, 4'h0);
        check("t2 addr held", bus.ram_addr, 32'd4);
        do_fetch(32'd4, 32'h12345678, "t2 readback");

        // 3: starvation bound; CPU requests again on every ready pulse.
        fetches = 0; writes = 0; at_write = -1;
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'd12;
        bus.ld_data = 32'hA5A5A5A5;
        bus.cpu_inst_complete = 1'b1;
        bus.cpu_pc_next = 32'd16;
        raised = 1'b1;
        for (int cyc = 0; cyc < 80 && fetches < 6; cyc++) begin
            @(negedge clk);
            if (raised) begin
                bus.cpu_inst_complete = 1'b0;
                raised = 1'b0;
            end
            if (bus.ram_we == 4'hF) begin
                writes++;
                at_write = fetches;
            end
            if (bus.ld_ack) bus.ld_req = 1'b0;
            if (bus.cpu_inst_ready) begin
                fetches++;
                if (fetches < 6) begin
                    bus.cpu_inst_complete = 1'b1;
                    bus.cpu_pc_next = 32'd16 + 32'(4 * fetches);
                    raised = 1'b1;
                end
            end
        end
        check("t3 total fetches", fetches, 6);
        check("t3 writes", writes, 1);
        check("t3 fetches before write", at_write, 4);
        check("t3 no ovf", bus.fetch_ovf, 1'b0);

        // 4: collision with starve_cnt=0 -> fetch first, then write.
        @(negedge clk);
        bus.cpu_inst_complete = 1'b1;
        bus.cpu_pc_next = 32'd20;
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'd24;
        bus.ld_data = 32'hCAFEF00D;
        @(negedge clk);
        check("t4 fetch addr", bus.ram_addr, 32'd20);
        check("t4 fetch we", bus.ram_we, 4'h0);
        bus.cpu_inst_complete = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4 ready", bus.cpu_inst_ready, 1'b1);
        check("t4 we during ready", bus.ram_we, 4'h0);
        @(negedge clk);
        check("t4 write we", bus.ram_we, 4'hF);
        check("t4 write addr", bus.ram_addr, 32'd24);
        check("t4 write data", bus.ram_data_in, 32'hCAFEF00D);
        @(negedge clk);
        check("t4 ack", bus.ld_ack, 1'b1);
        bus.ld_req = 1'b0;
        do_fetch(32'd24, 32'hCAFEF00D, "t4 readback");

        // 5: fetch_en low holds a pending fetch while the loader runs; overflow on a second edge.
        bus.fetch_en = 1'b0;
        bus.cpu_inst_complete = 1'b1;
        bus.cpu_pc_next = 32'd32;
        @(negedge clk);
        bus.cpu_inst_complete = 1'b0;
        check("t5 no fetch issued", bus.ram_addr, 32'd24);
        do_write(32'd48, 32'h0000_0048, "t5 w0");
        do_write(32'd52, 32'h0000_0052, "t5 w1");
        do_write(32'd56, 32'h0000_0056, "t5 w2");
        check("t5 no ready while disabled", bus.cpu_inst_ready, 1'b0);
        bus.cpu_inst_complete = 1'b1;
        bus.cpu_pc_next = 32'd40;
        @(negedge clk);
        bus.cpu_inst_complete = 1'b0;
        check("t5 ovf", bus.fetch_ovf, 1'b1);
        check("t5 still blocked", bus.ram_addr, 32'd56);
        bus.fetch_en = 1'b1;
        @(negedge clk);
        check("t5 original addr", bus.ram_addr, 32'd32);
        @(negedge clk);
        check("t5 ready E+2", bus.cpu_inst_ready, 1'b0);
        @(negedge clk);
        check("t5 ready E+3", bus.cpu_inst_ready, 1'b1);
        check("t5 inst", bus.cpu_inst, 32'h0000_3232);
        @(negedge clk);
        check("t5 ovf sticky", bus.fetch_ovf, 1'b1);
        do_fetch(32'd52, 32'h0000_0052, "t5 readback");

        // 6: reset in the write-issue cycle aborts the write.
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'd44;
        bus.ld_data = 32'hBAD0BAD0;
        @(negedge clk);
        check("t6 write issued", bus.ram_we, 4'hF);
        rst = 1'b1;
        #1;
        check("t6 we async clear", bus.ram_we, 4'h0);
        check("t6 addr clear", bus.ram_addr, 32'h0);
        check("t6 wdata clear", bus.ram_data_in, 32'h0);
        check("t6 inst clear", bus.cpu_inst, 32'h0);
        check("t6 ovf clear", bus.fetch_ovf, 1'b0);
        bus.ld_req = 1'b0;
        @(negedge clk);
        check("t6 no ack", bus.ld_ack, 1'b0);
        check("t6 no ready", bus.cpu_inst_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(32'd44, 32'h4444_4444, "t6 word unchanged");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
